// File: rtl/pixel_result_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_result_arbiter
//  Description : Round-robin arbiter that collects finished pixel results
//                from NUM_PROC Mandelbrot engines, converts (x, y) to a
//                linear frame-buffer address and performs a ready-gated
//                write. Counts stored pixels and pulses frame_done once per
//                complete H_RES x V_RES frame.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_result_arbiter #(
    parameter int NUM_PROC   = 4,
    parameter int ITER_WIDTH = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PROC-1:0]              eng_valid,
    input  logic [NUM_PROC*(19+ITER_WIDTH)-1:0] eng_data,
    output logic [NUM_PROC-1:0]              eng_ack,
    input  logic                             clr,
    input  logic                             wr_ready,
    output logic                             wr_en,
    output logic [18:0]                      wr_addr,
    output logic [ITER_WIDTH-1:0]            wr_data,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int          SLICE_W    = 19 + ITER_WIDTH;
    localparam int          PTR_W      = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam logic [18:0] LAST_PIXEL = 19'(H_RES * V_RES - 1);
    localparam logic [18:0] H_RES_W    = 19'(H_RES);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       grant_sel;
    logic [PTR_W-1:0]       scan_idx;
    logic [PTR_W-1:0]       next_ptr;
    logic [NUM_PROC-1:0]    grant_onehot;
    logic                   grant_found;
    logic [18:0]            pixel_count;
    logic                   clr_pend;
    logic                   do_grant;
    logic                   write_done;
    logic                   restart;

    logic [SLICE_W-1:0]     sel_slice;
    logic [9:0]             sel_x;
    logic [8:0]             sel_y;
    logic [ITER_WIDTH-1:0]  sel_iter;
    logic [18:0]            sel_addr;

    // Rotating-priority search: first valid engine at or after rr_ptr.
    always_comb begin
        grant_found  = 1'b0;
        grant_sel    = rr_ptr;
        grant_onehot = '0;
        scan_idx     = rr_ptr;
        for (int k = 0; k < NUM_PROC; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_PROC);
            if (!grant_found && eng_valid[scan_idx]) begin
                grant_found            = 1'b1;
                grant_sel              = scan_idx;
                grant_onehot[scan_idx] = 1'b1;
            end
        end
    end

    // Unpack the winning slice {x, y, iter}; y*H_RES is a constant multiply
    // (for 640 this reduces to (y<<9)+(y<<7)), result kept to 19 bits.
    assign sel_slice = eng_data[grant_sel*SLICE_W +: SLICE_W];
    assign sel_iter  = sel_slice[ITER_WIDTH-1:0];
    assign sel_y     = sel_slice[ITER_WIDTH +: 9];
    assign sel_x     = sel_slice[ITER_WIDTH+9 +: 10];
    assign sel_addr  = 19'(sel_y) * H_RES_W + 19'(sel_x);

    // Priority moves to the engine after the one just served.
    assign next_ptr  = (int'(grant_idx) == NUM_PROC - 1) ? '0 : grant_idx + 1'b1;

    // A clear seen now or earlier in this write restarts the frame at completion.
    assign restart   = clr | clr_pend;
    assign busy      = (state == WRITE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a clr in IDLE blocks the grant for that cycle.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        write_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (!clr && grant_found) begin
                    do_grant   = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (wr_en && wr_ready) begin
                    write_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant capture, write hold, pixel counting and frame restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            grant_idx   <= '0;
            pixel_count <= '0;
            clr_pend    <= 1'b0;
            eng_ack     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
        end else begin
            eng_ack    <= '0;
            frame_done <= 1'b0;

            if (do_grant) begin
                eng_ack   <= grant_onehot;
                grant_idx <= grant_sel;
                wr_en     <= 1'b1;
                wr_addr   <= sel_addr;
                wr_data   <= sel_iter;
            end

            if (state == IDLE && clr) begin
                pixel_count <= '0;
                rr_ptr      <= '0;
            end

            if (state == WRITE && clr) begin
                clr_pend <= 1'b1;
            end

            if (write_done) begin
                wr_en   <= 1'b0;
                wr_addr <= '0;
                wr_data <= '0;
                if (restart) begin
                    pixel_count <= '0;
                    rr_ptr      <= '0;
                    clr_pend    <= 1'b0;
                end else begin
                    rr_ptr <= next_ptr;
                    if (pixel_count == LAST_PIXEL) begin
                        pixel_count <= '0;
                        frame_done  <= 1'b1;
                    end else begin
                        pixel_count <= pixel_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_result_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_result_arbiter
//  Description : Self-checking bench for pixel_result_arbiter. A full-size
//                instance is driven by directed and random traffic and
//                compared to a transaction-level reference model; a small
//                10x6 instance exercises frame wrap and frame restart.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_result_arbiter;

    logic         clk = 1'b0;
    logic         reset;

    logic [3:0]   eng_valid;
    logic [107:0] eng_data;
    logic [3:0]   eng_ack;
    logic         clr;
    logic         wr_ready;
    logic         wr_en;
    logic [18:0]  wr_addr;
    logic [7:0]   wr_data;
    logic         busy;
    logic         frame_done;

    logic [3:0]   s_valid;
    logic [107:0] s_data;
    logic [3:0]   s_ack;
    logic         s_clr;
    logic         s_rdy;
    logic         s_wr_en;
    logic [18:0]  s_addr;
    logic [7:0]   s_wdata;
    logic         s_busy;
    logic         s_fd;

    int total = 0;
    int bad   = 0;

    // Reference model state (transaction level).
    bit m_busy = 0;
    bit m_clrp = 0;
    int m_ptr  = 0;
    int m_g    = 0;
    int m_addr = 0;
    int m_data = 0;

    pixel_result_arbiter dut (
        .clk(clk), .reset(reset),
        .eng_valid(eng_valid), .eng_data(eng_data), .eng_ack(eng_ack),
        .clr(clr), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .frame_done(frame_done)
    );

    pixel_result_arbiter #(.NUM_PROC(4), .ITER_WIDTH(8), .H_RES(10), .V_RES(6)) dut_s (
        .clk(clk), .reset(reset),
        .eng_valid(s_valid), .eng_data(s_data), .eng_ack(s_ack),
        .clr(s_clr), .wr_ready(s_rdy), .wr_en(s_wr_en), .wr_addr(s_addr),
        .wr_data(s_wdata), .busy(s_busy), .frame_done(s_fd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Predict the effect of the coming edge from the current inputs, then
    // advance one cycle and compare every output to the prediction.
    task automatic step();
        logic [3:0]  e_ack;
        logic [26:0] sl;
        bit          found;
        e_ack = 4'b0000;
        found = 0;
        if (!m_busy) begin
            if (clr) begin
                m_ptr = 0;
            end else if (eng_valid != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 4;
                    if (!found && eng_valid[idx]) begin
                        found = 1;
                        m_g   = idx;
                    end
                end
                sl     = eng_data[m_g*27 +: 27];
                m_addr = (int'(sl[16:8]) * 640 + int'(sl[26:17])) % 524288;
                m_data = int'(sl[7:0]);
                m_busy = 1;
                e_ack  = 4'(1 << m_g);
            end
        end else begin
            if (clr) m_clrp = 1;
            if (wr_ready) begin
                m_busy = 0;
                if (m_clrp) begin
                    m_ptr  = 0;
                    m_clrp = 0;
                end else begin
                    m_ptr = (m_g + 1) % 4;
                end
            end
        end
        tick();
        check("ack",        32'(eng_ack),    32'(e_ack));
        check("wr_en",      32'(wr_en),      32'(m_busy));
        check("busy",       32'(busy),       32'(m_busy));
        check("wr_addr",    32'(wr_addr),    m_busy ? 32'(m_addr) : 32'd0);
        check("wr_data",    32'(wr_data),    m_busy ? 32'(m_data) : 32'd0);
        check("frame_done", 32'(frame_done), 32'd0);
    endtask

    // One write through the small instance; optional clr during its WRITE.
    task automatic swrite(input int x, input int y, input bit doclr, input bit exp_fd);
        s_data[26:0] = {10'(x), 9'(y), 8'($urandom)};
        s_valid      = 4'b0001;
        tick();
        check("s_addr", 32'(s_addr), 32'(y * 10 + x));
        s_valid = 4'b0000;
        if (doclr) begin
            s_clr = 1'b1;
            s_rdy = 1'b0;
            tick();
            s_clr = 1'b0;
            s_rdy = 1'b1;
        end
        tick();
        check("s_frame_done", 32'(s_fd), 32'(exp_fd));
    endtask

    initial begin
        reset     = 1'b0;
        eng_valid = '0;
        eng_data  = '0;
        clr       = 1'b0;
        wr_ready  = 1'b1;
        s_valid   = '0;
        s_data    = '0;
        s_clr     = 1'b0;
        s_rdy     = 1'b1;

        // Reset state.
        repeat (3) tick();
        check("rst_ack",   32'(eng_ack),    32'd0);
        check("rst_wr_en", 32'(wr_en),      32'd0);
        check("rst_addr",  32'(wr_addr),    32'd0);
        check("rst_data",  32'(wr_data),    32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_fd",    32'(frame_done), 32'd0);
        reset = 1'b1;
        tick();

        // Single request: engine 2, x=5 y=3 iter=0x7F.
        eng_data[2*27 +: 27] = {10'd5, 9'd3, 8'h7F};
        eng_valid = 4'b0100;
        step();
        check("single_ack",  32'(eng_ack), 32'h4);
        check("single_addr", 32'(wr_addr), 32'd1925);
        check("single_data", 32'(wr_data), 32'h7F);
        eng_valid = 4'b0000;
        step();
        check("single_busy_low", 32'(busy), 32'd0);

        // Fairness: restart the pointer, hold all engines valid.
        clr = 1'b1;
        step();
        clr = 1'b0;
        eng_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            step();
            check("fair_order", 32'(eng_ack), 32'(1 << (n % 4)));
            eng_data[(n % 4)*27 +: 27] = 27'($urandom);
            step();
        end

        // Backpressure: five cycles of wr_ready low after the grant.
        wr_ready = 1'b0;
        step();
        for (int n = 0; n < 5; n++) step();
        wr_ready = 1'b1;
        step();
        step();
        check("bp_next_grant", 32'(eng_ack), 32'h2);

        // Random traffic, including backpressure, clr and out-of-range x/y.
        for (int n = 0; n < 400; n++) begin
            eng_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) eng_data[i*27 +: 27] = 27'($urandom);
            wr_ready = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 15) == 0);
            step();
        end

        // Async reset in the ack cycle of a write.
        clr       = 1'b0;
        eng_valid = 4'b0000;
        wr_ready  = 1'b1;
        step();
        step();
        eng_valid = 4'b0001;
        wr_ready  = 1'b0;
        step();
        #3;
        reset = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_en),   32'd0);
        check("arst_ack",   32'(eng_ack), 32'd0);
        check("arst_busy",  32'(busy),    32'd0);
        m_busy = 0;
        m_clrp = 0;
        m_ptr  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        wr_ready  = 1'b1;
        eng_valid = 4'b0110;
        step();
        check("arst_first_grant", 32'(eng_ack), 32'h2);
        eng_valid = 4'b0000;
        step();

        // Frame wrap on the 10x6 instance: full frame, clr-suppressed frame,
        // then a full frame counted from zero again.
        for (int p = 0; p < 60; p++) swrite(p % 10, p / 10, 1'b0, p == 59);
        for (int p = 0; p < 59; p++) swrite(p % 10, p / 10, 1'b0, 1'b0);
        swrite(9, 5, 1'b1, 1'b0);
        for (int p = 0; p < 60; p++) swrite(p % 10, p / 10, 1'b0, p == 59);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_result_arbiter.md
Name: pixel_result_arbiter

Overview:
- Collects finished pixel results from the NUM_PROC Mandelbrot engines and shares the single frame-buffer write port between them.
- Uses rotating (round-robin) priority so no engine starves.
- Converts each result's (x, y) to a linear frame-buffer address and performs a ready-gated write.
- Acknowledges the winning engine, counts written pixels and pulses frame_done when a full 640x480 frame has been stored.

Parameters:
- NUM_PROC, 4, number of engines (requesters).
- ITER_WIDTH, 8, width of the iteration-count result per pixel.
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- eng_valid  in  NUM_PROC  bit i high: engine i holds a finished result.
- eng_data  in  NUM_PROC*(19+ITER_WIDTH)  engine i slice = {x[9:0], y[8:0], iter[ITER_WIDTH-1:0]}, slice 0 at the LSBs.
- eng_ack  out  NUM_PROC  one-hot, one-cycle pulse; engine i's result has been taken.
- clr  in  1  synchronous frame restart; clears pixel count and priority pointer.
- wr_ready  in  1  frame-buffer port accepts the write this cycle.
- wr_en  out  1  write request.
- wr_addr  out  19  y*H_RES + x.
- wr_data  out  ITER_WIDTH  iteration count.
- busy  out  1  high while a write is pending (state WRITE).
- frame_done  out  1  one-cycle pulse when the last pixel of a frame has been written.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rr_ptr=0; pixel_count=0; clr_pend=0; eng_ack=0; wr_en=0; wr_addr=0; wr_data=0; busy=0; frame_done=0. Outputs stay at these values until the first rising edge after reset deasserts.
- States: IDLE, WRITE.
- IDLE:
  - If any eng_valid bit is high, grant g = first index with eng_valid set, searching rr_ptr, rr_ptr+1, ... modulo NUM_PROC.
  - At that edge: capture slice g; wr_addr = (y<<9)+(y<<7)+x as a 19-bit unsigned value; wr_data = iter; state -> WRITE.
  - Result: eng_ack[g]=1, wr_en=1, busy=1 in the cycle after grant; grant-to-ack latency is 1 cycle.
  - If no eng_valid bit is high: remain in IDLE, all outputs low.
- WRITE:
  - eng_ack is high only in the first WRITE cycle.
  - wr_en, wr_addr and wr_data are held stable until wr_ready is sampled high.
  - eng_valid is ignored for the whole WRITE state.
  - On the edge where wr_en and wr_ready are both high: state -> IDLE; rr_ptr = (g+1) mod NUM_PROC; pixel_count increments.
- Frame completion:
  - If pixel_count == H_RES*V_RES-1 when a write completes, pixel_count wraps to 0 and frame_done pulses for the following cycle.
- Engine handshake:
  - An engine must deassert eng_valid, or present a new result, no later than the cycle after its eng_ack.
  - The arbiter never acks the same valid twice, because at least one WRITE cycle separates consecutive grants.
- Peak throughput: one pixel per 2 cycles with wr_ready tied high.
- Ties: simultaneous valids resolve by rotating priority only; fixed index order is never used.
- clr:
  - Sampled in IDLE: pixel_count=0 and rr_ptr=0 take effect that edge, and no grant is made that cycle.
  - Sampled in WRITE: sets clr_pend; the in-flight write still completes normally.
  - On write completion with clr_pend set: pixel_count=0, rr_ptr=0, clr_pend=0, frame_done suppressed.
- Out-of-range input: x>=H_RES or y>=V_RES is still written, using the computed address truncated to 19 bits, and is still counted. No range checking is done.
- Reset mid-WRITE: the write is abandoned, wr_en drops immediately, and no eng_ack is re-issued.

Test Plan:
- Single request: wr_ready=1, engine 2 presents x=5, y=3, iter=0x7F -> one cycle later eng_ack=4'b0100, wr_en=1, wr_addr=1925, wr_data=0x7F; busy low 2 cycles after the grant.
- Fairness: all four eng_valid held high, each re-presented one cycle after its ack, wr_ready=1 -> acks in order 0,1,2,3,0,1,...; one ack every 2 cycles.
- Backpressure: wr_ready=0 for 5 cycles after a grant -> wr_en, wr_addr and wr_data stable for 6 cycles; no new ack; grant issued after wr_ready rises.
- Frame wrap: drive 307200 writes (x 0..639, y 0..479) -> frame_done pulses exactly once, after the write to address 307199; pixel_count returns to 0; last address written = 307199.
- clr during WRITE with wr_ready=0 -> write completes when wr_ready rises; pixel_count=0; next grant starts from engine 0; no frame_done.
- Async reset asserted mid-WRITE -> wr_en, eng_ack and busy go to 0 without waiting for a clock edge; after release, the first grant goes to the lowest valid index.
